// File: rtl/pad_cfg_pkg.sv
// rtl/pad_cfg_pkg.sv - register offsets, pad config type and APB FSM states for pad_cfg_regs
package pad_cfg_pkg;

    localparam logic [7:0] PADCFG_BASE = 8'h00;
    localparam logic [7:0] BOOTSEL_OFS = 8'h40;
    localparam logic [7:0] LOCK_OFS    = 8'h44;

    typedef logic [5:0] pad_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } apb_state_e;

endpackage

// File: rtl/pad_bootsel_sampler.sv
// rtl/pad_bootsel_sampler.sv - synchronizes boot-select pads and captures them once after a settle delay
module pad_bootsel_sampler
    import pad_cfg_pkg::*;
#(
    parameter int BOOTSEL_SETTLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] bootsel_pad_i,
    output logic [1:0] bootsel_o,
    output logic       bootsel_valid_o
);

    localparam int CW = $clog2(BOOTSEL_SETTLE) + 1;
    localparam logic [CW-1:0] LAST = CW'(BOOTSEL_SETTLE - 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1           <= '0;
            sync2           <= '0;
            cnt             <= '0;
            bootsel_o       <= '0;
            bootsel_valid_o <= 1'b0;
        end else begin
            sync1 <= bootsel_pad_i;
            sync2 <= sync1;
            // Counter parks at LAST; capture happens exactly once per reset.
            if (cnt == LAST) begin
                if (!bootsel_valid_o) begin
                    bootsel_o       <= sync2;
                    bootsel_valid_o <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_cfg_regs.sv
// rtl/pad_cfg_regs.sv - APB pad configuration registers and boot-select capture
// Optional LOCK register at 0x44 enabled by PAD_CFG_LOCK_EN.
module pad_cfg_regs
    import pad_cfg_pkg::*;
#(
    parameter int NUM_PADS       = 48,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int BOOTSEL_SETTLE = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [31:0]               apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [31:0]               apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    input  logic [1:0]                bootsel_pad_i,
    output logic [NUM_PADS*6-1:0]     pad_cfg_o,
    output logic [1:0]                bootsel_o,
    output logic                      bootsel_valid_o
);

    localparam int NUM_WORDS = NUM_PADS / 4;

    apb_state_e  state;
    apb_state_e  next_state;
    pad_cfg_t    pad_cfg_q [NUM_PADS];
    logic [7:0]  word_ofs;
    logic [5:0]  pad_word;
    logic        padcfg_hit;
    logic        bootsel_hit;
    logic        lock_hit;
    logic        lock_q;
    logic        commit;
    logic        wr_pads;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_ok;

    pad_bootsel_sampler #(
        .BOOTSEL_SETTLE(BOOTSEL_SETTLE)
    ) u_bootsel (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bootsel_pad_i  (bootsel_pad_i),
        .bootsel_o      (bootsel_o),
        .bootsel_valid_o(bootsel_valid_o)
    );

    assign word_ofs    = {apb_paddr_i[7:2], 2'b00};
    assign pad_word    = apb_paddr_i[7:2] - PADCFG_BASE[7:2];
    assign padcfg_hit  = pad_word < 6'(NUM_WORDS);
    assign bootsel_hit = word_ofs == BOOTSEL_OFS;

`ifdef PAD_CFG_LOCK_EN
    assign lock_hit  = word_ofs == LOCK_OFS;
    assign unused_ok = ^{apb_paddr_i, apb_pwdata_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (commit && lock_hit && apb_pwrite_i && apb_pwdata_i[0]) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign lock_hit  = 1'b0;
    assign lock_q    = 1'b0;
    assign unused_ok = ^{apb_paddr_i, apb_pwdata_i, LOCK_OFS};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Losing psel mid-access aborts back to IDLE; RESP always lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (apb_psel_i && apb_penable_i) next_state = WAIT;
            WAIT:    next_state = apb_psel_i ? RESP : IDLE;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        commit = (state == WAIT) && apb_psel_i;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        wr_pads = 1'b0;
        if (padcfg_hit) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (pad_word == 6'(w)) begin
                    for (int j = 0; j < 4; j++) begin
                        rd_data[8*j +: 8] = {2'b00, pad_cfg_q[4*w+j]};
                    end
                end
            end
            rd_err  = apb_pwrite_i && lock_q;
            wr_pads = apb_pwrite_i && !lock_q;
        end else if (bootsel_hit) begin
            rd_data = {23'b0, bootsel_valid_o, 6'b0, bootsel_o};
            rd_err  = apb_pwrite_i;
        end else if (lock_hit) begin
            rd_data = {31'b0, lock_q};
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            apb_pready_o  <= 1'b0;
            apb_prdata_o  <= '0;
            apb_pslverr_o <= 1'b0;
        end else begin
            apb_pready_o <= commit;
            if (commit) begin
                apb_prdata_o  <= rd_data;
                apb_pslverr_o <= rd_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                pad_cfg_q[p] <= '0;
            end
        end else if (commit && wr_pads) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (pad_word == 6'(w)) begin
                    for (int j = 0; j < 4; j++) begin
                        pad_cfg_q[4*w+j] <= apb_pwdata_i[8*j +: 6];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad_out
        assign pad_cfg_o[6*p +: 6] = pad_cfg_q[p];
    end

endmodule
